// File: rtl/cjb_risc_hmmiop_cu.sv
// Moore control unit for the three-bus Harvard 8-bit RISC with memory-mapped I/O.
// Sequences FETCH/DECODE/ADDR/MEM and drives every datapath strobe and bus select.
module cjb_risc_hmmiop_cu #(
    parameter logic [9:0] IO_ADDR = 10'h3FF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] IW,
    input  logic [3:0] SR_CNVZ,
    input  logic [9:0] MARout,
    output logic       RST_PC,
    output logic       LD_PC,
    output logic       CNT_PC,
    output logic       LD_IR,
    output logic       LD_R0,
    output logic       LD_R1,
    output logic       LD_R2,
    output logic       LD_R3,
    output logic       LD_SR,
    output logic       LD_MABR,
    output logic       LD_MAXR,
    output logic       LD_MAR,
    output logic       RW,
    output logic       LD_IPDR,
    output logic       LD_OPDR,
    output logic [1:0] IB0_SEL,
    output logic [1:0] IB1_SEL,
    output logic [1:0] IB2_SEL,
    output logic [3:0] ALU_FS,
    output logic       push,
    output logic       pop,
    output logic       ipstksel,
    output logic       Halted
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ADDR   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_STK  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t state_q, state_d;

    logic [3:0] opcode;
    logic [1:0] ri;
    logic [1:0] rj;
    logic       is_io;
    logic       jmp_taken;
    logic [3:0] ld_r;
    logic [1:0] flag_idx;

    assign opcode    = IW[7:4];
    assign ri        = IW[3:2];
    assign rj        = IW[1:0];
    assign is_io     = (MARout == IO_ADDR);
    // Flag order in SR is {C,N,V,Z}, so subcode 00 selects bit 3.
    assign flag_idx  = 2'd3 - rj;
    assign jmp_taken = IW[3] | (SR_CNVZ[flag_idx] ^ IW[2]);

    assign {LD_R3, LD_R2, LD_R1, LD_R0} = ld_r;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        RST_PC   = 1'b0;
        LD_PC    = 1'b0;
        CNT_PC   = 1'b0;
        LD_IR    = 1'b0;
        ld_r     = 4'b0000;
        LD_SR    = 1'b0;
        LD_MABR  = 1'b0;
        LD_MAXR  = 1'b0;
        LD_MAR   = 1'b0;
        RW       = 1'b0;
        LD_IPDR  = 1'b0;
        LD_OPDR  = 1'b0;
        IB0_SEL  = 2'b00;
        IB1_SEL  = 2'b00;
        IB2_SEL  = 2'b00;
        ALU_FS   = 4'h0;
        push     = 1'b0;
        pop      = 1'b0;
        ipstksel = 1'b0;
        Halted   = 1'b0;

        case (state_q)
            S_RST: begin
                RST_PC  = 1'b1;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                LD_IR   = 1'b1;
                CNT_PC  = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                state_d = S_FETCH;
                if (!opcode[3]) begin
                    ALU_FS  = {1'b0, opcode[2:0]};
                    IB0_SEL = ri;
                    IB1_SEL = rj;
                    IB2_SEL = 2'b01;
                    ld_r    = 4'b0001 << ri;
                    LD_SR   = 1'b1;
                end else begin
                    case (opcode)
                        OP_MOV: begin
                            IB0_SEL = rj;
                            ld_r    = 4'b0001 << ri;
                        end
                        OP_LD, OP_ST: begin
                            // MAXR takes Rj through IB0 -> IB2 while the base byte is latched.
                            LD_MABR = 1'b1;
                            LD_MAXR = 1'b1;
                            CNT_PC  = 1'b1;
                            IB0_SEL = rj;
                            state_d = S_ADDR;
                        end
                        OP_JMP: begin
                            LD_MABR = 1'b1;
                            LD_MAXR = 1'b1;
                            CNT_PC  = 1'b1;
                            state_d = S_ADDR;
                        end
                        OP_STK: begin
                            if (rj == 2'b00) begin
                                IB0_SEL = ri;
                                push    = 1'b1;
                            end else if (rj == 2'b01) begin
                                IB2_SEL  = 2'b11;
                                ipstksel = 1'b1;
                                pop      = 1'b1;
                                ld_r     = 4'b0001 << ri;
                            end
                        end
                        OP_HALT: state_d = S_HALT;
                        default: ;
                    endcase
                end
            end

            S_ADDR: begin
                LD_MAR  = 1'b1;
                LD_IPDR = 1'b1;
                if (opcode == OP_JMP) begin
                    LD_PC   = jmp_taken;
                    state_d = S_FETCH;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEM: begin
                state_d = S_FETCH;
                if (opcode == OP_LD) begin
                    IB2_SEL = is_io ? 2'b11 : 2'b10;
                    ld_r    = 4'b0001 << ri;
                end else if (opcode == OP_ST) begin
                    IB0_SEL = ri;
                    LD_OPDR = is_io;
                    RW      = ~is_io;
                end
            end

            S_HALT: begin
                Halted  = 1'b1;
                state_d = S_HALT;
            end

            default: state_d = S_RST;
        endcase
    end

endmodule

// File: doc/cjb_risc_hmmiop_cu.md
Name: cjb_risc_hmmiop_cu

Overview:
Control unit (CU) for the three-bus, Harvard, memory-mapped-I/O 8-bit RISC datapath.
It is a Moore-style FSM. It consumes the instruction word, the registered CNVZ flags and the memory address register, and it drives every load, select, count and push/pop strobe of the datapath.
It sits beside the datapath in the top level; the datapath's control inputs connect one-to-one to these outputs.

Parameters:
IO_ADDR, 10'h3FF, data-memory address mapped to the I/O ports (load reads IPDR, store writes OPDR)

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
IW  input  8  instruction register contents: [7:4] opcode, [3:2] Ri, [1:0] Rj/subcode
SR_CNVZ  input  4  status register {C,N,V,Z}
MARout  input  10  current memory address register
RST_PC, LD_PC, CNT_PC, LD_IR  output  1 each  PC/IR controls
LD_R0, LD_R1, LD_R2, LD_R3  output  1 each  register file loads
LD_SR, LD_MABR, LD_MAXR, LD_MAR  output  1 each  flag and address register loads
RW  output  1  data memory write enable (1 = write)
LD_IPDR, LD_OPDR  output  1 each  I/O data register loads
IB0_SEL, IB1_SEL, IB2_SEL  output  2 each  bus selects. IB0/IB1: register number. IB2: 00 = IB0, 01 = ALU, 10 = DM, 11 = stack/IPDR mux
ALU_FS  output  4  ALU function select
push, pop  output  1 each  hardware stack strobes
ipstksel  output  1  1 = stack output, 0 = IPDR onto IB2 path
Halted  output  1  high in S_HALT

Behaviour:
Reset:
- Reset=1 forces S_RST immediately.
- In S_RST, every output is 0 except RST_PC=1.
- Reset mid-instruction aborts the instruction; no write strobe is asserted after Reset rises.

FSM state sequence:
- S_RST -> S_FETCH.
- S_FETCH: LD_IR=1, CNT_PC=1 -> S_DECODE.
- S_DECODE executes single-word instructions, then returns to S_FETCH. These take 2 cycles.
- S_DECODE on two-word instructions (LD, ST, JMP): LD_MABR=1, LD_MAXR=1, CNT_PC=1 -> S_ADDR.
  - For LD/ST: IB0_SEL=Rj, IB2_SEL=00, so MAXR gets sign-extended Rj.
- S_ADDR: LD_MAR=1, LD_IPDR=1. MAR updates on the falling edge inside S_ADDR.
  - JMP: LD_PC=1 if the condition is true -> S_FETCH. JMP takes 3 cycles, taken or not.
  - LD/ST -> S_MEM.
- S_MEM: data access, then -> S_FETCH. LD/ST take 4 cycles.
- S_HALT: all strobes 0, Halted=1. Left only by Reset.

Opcodes:
- 0x0-0x7, ALU Ri <- Ri op Rj:
  - ALU_FS = {1'b0, IW[6:4]}, IB0_SEL=Ri, IB1_SEL=Rj, IB2_SEL=01.
  - LD_Ri=1, LD_SR=1.
- 0x8, MOV Ri <- Rj: IB0_SEL=Rj, IB2_SEL=00, LD_Ri=1. SR is unchanged.
- 0x9, LD Ri <- M[base*4 + Rj]:
  - The base byte is the second word.
  - In S_MEM, if MARout == IO_ADDR: IB2_SEL=11, ipstksel=0. Otherwise IB2_SEL=10.
  - LD_Ri=1 in both cases.
- 0xA, ST M[...] <- Ri:
  - In S_MEM: IB0_SEL=Ri, IB2_SEL=00.
  - If MARout == IO_ADDR: LD_OPDR=1, RW=0. Otherwise RW=1.
- 0xC, stack:
  - Subcode 00 = PUSH Ri: IB0_SEL=Ri, IB2_SEL=00, push=1.
  - Subcode 01 = POP Ri: IB2_SEL=11, ipstksel=1, pop=1, LD_Ri=1.
  - Subcodes 1x are NOPs.
- 0xD, JMP PC-relative; the offset is the second word.
  - IW[3]=1: unconditional.
  - Otherwise the flag is SR_CNVZ[3-IW[1:0]] (00=C, 01=N, 10=V, 11=Z). The jump is taken when flag XOR IW[2] is 1.
- 0xB, 0xE: NOP.
- 0xF: HALT.

Output rules:
- Outputs not listed for a state are 0. Selects default to 00.
- LD_Rx is a one-hot decode of the destination register; at most one is high.
- LD_OPDR and RW are never high in the same cycle.
- push and pop are never high in the same cycle.
- IB2 writes occur only in the listed states.

Test Plan:
- Reset released, PM[0]=0x0? (ADD R1,R2) -> RST_PC pulses 1 cycle; FETCH then DECODE: IB0_SEL=01, IB1_SEL=10, IB2_SEL=01, LD_R1=1, LD_SR=1.
- Reset released, PM[0]=0x46 (ALU op4 R1,R2) -> RST_PC pulses 1 cycle; FETCH then DECODE: ALU_FS=4, IB0_SEL=01, IB1_SEL=10, IB2_SEL=01, LD_R1=1, LD_SR=1.
- IW=0x96 (LD R1, base, R2), MARout=10'h021 in S_MEM -> IB2_SEL=10, LD_R1=1. Sequence FETCH, DECODE (LD_MABR=LD_MAXR=CNT_PC=1), ADDR (LD_MAR=1), MEM.
- IW=0xA4 (ST R1), MARout=10'h3FF -> LD_OPDR=1, RW=0. Repeat with MARout=10'h010 -> RW=1, LD_OPDR=0.
- IW=0xD3 with SR_CNVZ=4'b0001 -> LD_PC=1 in S_ADDR. With SR_CNVZ=4'b0000 -> LD_PC=0 and the next state is S_FETCH.
- IW=0xC4 then 0xC9 -> push=1 with IB0_SEL=01; then pop=1, ipstksel=1, IB2_SEL=11, LD_R2=1. Never both push and pop.
- IW=0xF0 -> Halted=1 and all strobes 0 for 10 cycles. Reset asserted mid-S_MEM of a store -> RW drops to 0 asynchronously and the FSM is in S_RST.
